// File: rtl/huffman_pkg.sv
// huffman_pkg: shared widths, FSM states and size/amplitude helpers for the symbol sequencer
package huffman_pkg;
    localparam int RUN_W  = 4;
    localparam int SIZE_W = 4;
    localparam logic [RUN_W-1:0] ZRL_RUN = 4'd15;
    // working width of the helpers; wide enough for any coefficient width up to 15 bits
    localparam int VAL_W  = 16;

    typedef enum logic [1:0] {IDLE, DC, SCAN, HOLD} state_t;

    // bit length of |v|
    function automatic logic [SIZE_W-1:0] size_cat(input logic signed [VAL_W-1:0] v);
        logic [VAL_W-1:0] a;
        a = v[VAL_W-1] ? VAL_W'(-v) : VAL_W'(v);
        size_cat = '0;
        for (int i = 0; i < VAL_W; i++)
            if (a[i]) size_cat = SIZE_W'(i + 1);
    endfunction

    // positive values as-is, negative values in ones' complement, masked to size bits
    function automatic logic [VAL_W-1:0] amp_bits(input logic signed [VAL_W-1:0] v,
                                                  input logic [SIZE_W-1:0] size);
        amp_bits = (VAL_W'(v) - VAL_W'(v[VAL_W-1])) & ((VAL_W'(1) << size) - VAL_W'(1));
    endfunction
endpackage

// File: rtl/huffman_symbol_sequencer_if.sv
// huffman_symbol_sequencer_if: block-in / symbol-out handshake bundle of the symbol sequencer
interface huffman_symbol_sequencer_if
    import huffman_pkg::*;
#(
    parameter int COEF_W   = 10,
    parameter int NUM_COEF = 64,
    parameter int CH_W     = 2
);
    logic                       blk_valid;
    logic                       blk_ready;
    logic [CH_W-1:0]            blk_ch;
    logic [NUM_COEF*COEF_W-1:0] blk_coef;
    logic                       dc_reset;
    logic                       sym_valid;
    logic                       sym_ready;
    logic                       sym_is_dc;
    logic [CH_W-1:0]            sym_ch;
    logic [RUN_W-1:0]           sym_run;
    logic [SIZE_W-1:0]          sym_size;
    logic [COEF_W:0]            sym_amp;
    logic                       sym_eob;
    logic                       sym_zrl;
    logic                       sym_last;

    modport master (
        output blk_valid, blk_ch, blk_coef, dc_reset, sym_ready,
        input  blk_ready, sym_valid, sym_is_dc, sym_ch, sym_run, sym_size, sym_amp,
               sym_eob, sym_zrl, sym_last
    );

    modport slave (
        input  blk_valid, blk_ch, blk_coef, dc_reset, sym_ready,
        output blk_ready, sym_valid, sym_is_dc, sym_ch, sym_run, sym_size, sym_amp,
               sym_eob, sym_zrl, sym_last
    );
endinterface

// File: rtl/huff_size_amp.sv
// huff_size_amp: combinational signed value -> JPEG size category and amplitude bits
module huff_size_amp
    import huffman_pkg::*;
#(
    parameter int W = 11
) (
    input  logic signed [W-1:0] val,
    output logic [SIZE_W-1:0]   size,
    output logic [W-1:0]        amp
);
    logic signed [VAL_W-1:0] ext;

    assign ext  = {{(VAL_W-W){val[W-1]}}, val};
    assign size = size_cat(ext);
    assign amp  = W'(amp_bits(ext, size));
endmodule

// File: rtl/huffman_symbol_sequencer.sv
// huffman_symbol_sequencer: zigzag block -> DC-difference, AC (run,size), ZRL and EOB symbols.
// Define HUFF_SEQ_STATS_EN to add stat_sym_cnt / stat_zero_blk block statistics outputs.
module huffman_symbol_sequencer
    import huffman_pkg::*;
#(
    parameter int COEF_W   = 10,
    parameter int NUM_COEF = 64,
    parameter int NUM_CH   = 3,
    parameter int CH_W     = 2
) (
    input logic clock,
    input logic reset,
`ifdef HUFF_SEQ_STATS_EN
    output logic [7:0] stat_sym_cnt,
    output logic       stat_zero_blk,
`endif
    huffman_symbol_sequencer_if.slave bus
);
    localparam int K_W = $clog2(NUM_COEF + 1);

    state_t                     state, state_nx;
    logic [NUM_COEF*COEF_W-1:0] coef_q;
    logic [CH_W-1:0]            ch_q, ch_in;
    logic [K_W-1:0]             k, last_nz, last_nz_q;
    logic [RUN_W-1:0]           run, run_nx;
    logic signed [COEF_W-1:0]   pred [NUM_CH];
    logic signed [COEF_W-1:0]   coef0_in, pred_in, cur;
    logic signed [COEF_W:0]     diff, ac_val;
    logic [SIZE_W-1:0]          dc_size, ac_size;
    logic [COEF_W:0]            dc_amp, ac_amp;
    logic                       accept, sym_fire, past, emit, is_eob, is_zrl, ac_last;
    logic                       sym_valid, sym_is_dc, sym_eob, sym_zrl, sym_last;
    logic [RUN_W-1:0]           sym_run;
    logic [SIZE_W-1:0]          sym_size;
    logic [COEF_W:0]            sym_amp;

    assign accept   = bus.blk_valid && bus.blk_ready;
    assign sym_fire = sym_valid && bus.sym_ready;
    assign ch_in    = 32'(bus.blk_ch) < NUM_CH ? bus.blk_ch : '0;

    // DC difference is formed straight from the offered block so it is valid the cycle after accept
    assign coef0_in = bus.blk_coef[COEF_W-1:0];
    assign pred_in  = bus.dc_reset ? '0 : pred[ch_in];
    assign diff     = {coef0_in[COEF_W-1], coef0_in} - {pred_in[COEF_W-1], pred_in};

    // coefficients shift down one slot per SCAN cycle, so index k always sits in slot 1
    assign cur     = coef_q[2*COEF_W-1:COEF_W];
    assign ac_val  = {cur[COEF_W-1], cur};
    assign past    = k > last_nz_q;
    assign is_eob  = past;
    assign is_zrl  = !past && cur == '0 && run == ZRL_RUN;
    assign emit    = past || cur != '0 || run == ZRL_RUN;
    assign run_nx  = emit ? '0 : run + 1'b1;
    assign ac_last = !past && k == K_W'(NUM_COEF - 1);

    huff_size_amp #(.W(COEF_W + 1)) u_dc (.val(diff),   .size(dc_size), .amp(dc_amp));
    huff_size_amp #(.W(COEF_W + 1)) u_ac (.val(ac_val), .size(ac_size), .amp(ac_amp));

    assign bus.blk_ready = state == IDLE;
    assign bus.sym_valid = sym_valid;
    assign bus.sym_is_dc = sym_is_dc;
    assign bus.sym_ch    = ch_q;
    assign bus.sym_run   = sym_run;
    assign bus.sym_size  = sym_size;
    assign bus.sym_amp   = sym_amp;
    assign bus.sym_eob   = sym_eob;
    assign bus.sym_zrl   = sym_zrl;
    assign bus.sym_last  = sym_last;

    // highest AC index holding a nonzero coefficient, 0 when the AC part is all zero
    always_comb begin
        last_nz = '0;
        for (int i = 1; i < NUM_COEF; i++)
            if (bus.blk_coef[i*COEF_W +: COEF_W] != '0) last_nz = K_W'(i);
    end

    // next state: DC and HOLD both wait for the symbol handshake
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? DC : IDLE;
            SCAN:    state_nx = emit ? HOLD : SCAN;
            default: state_nx = sym_fire ? (sym_last ? IDLE : SCAN) : HOLD;
        endcase
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // capture the block on accept, walk AC coefficients in SCAN, hold each symbol until taken
    always_ff @(posedge clock) begin
        if (reset) begin
            coef_q    <= '0;
            ch_q      <= '0;
            last_nz_q <= '0;
            k         <= '0;
            run       <= '0;
            sym_valid <= 1'b0;
            sym_is_dc <= 1'b0;
            sym_run   <= '0;
            sym_size  <= '0;
            sym_amp   <= '0;
            sym_eob   <= 1'b0;
            sym_zrl   <= 1'b0;
            sym_last  <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                coef_q    <= bus.blk_coef;
                ch_q      <= ch_in;
                last_nz_q <= last_nz;
                k         <= K_W'(1);
                run       <= '0;
                sym_valid <= 1'b1;
                sym_is_dc <= 1'b1;
                sym_run   <= '0;
                sym_size  <= dc_size;
                sym_amp   <= dc_amp;
                sym_eob   <= 1'b0;
                sym_zrl   <= 1'b0;
                sym_last  <= 1'b0;
            end
        end else if (state == SCAN) begin
            coef_q <= coef_q >> COEF_W;
            k      <= k + 1'b1;
            run    <= run_nx;
            if (emit) begin
                sym_valid <= 1'b1;
                sym_is_dc <= 1'b0;
                sym_run   <= run;
                sym_size  <= ac_size;
                sym_amp   <= ac_amp;
                sym_eob   <= is_eob;
                sym_zrl   <= is_zrl;
                sym_last  <= is_eob || ac_last;
            end
        end else if (sym_fire) begin
            sym_valid <= 1'b0;
        end
    end

    // predictors: cleared by dc_reset with the block, loaded with its DC coefficient in DC
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++)
            if (reset || (accept && bus.dc_reset)) pred[i] <= '0;
            else if (state == DC && CH_W'(i) == ch_q) pred[i] <= coef_q[COEF_W-1:0];
    end

`ifdef HUFF_SEQ_STATS_EN
    logic [7:0] sym_cnt;

    // count taken symbols, publish the block total on its last symbol, flag all-zero-AC blocks
    always_ff @(posedge clock) begin
        if (reset) begin
            sym_cnt       <= '0;
            stat_sym_cnt  <= '0;
            stat_zero_blk <= 1'b0;
        end else begin
            stat_zero_blk <= accept && last_nz == '0;
            if (sym_fire) begin
                sym_cnt <= sym_last ? '0 : sym_cnt + 1'b1;
                if (sym_last) stat_sym_cnt <= sym_cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_huffman_symbol_sequencer.sv
// tb_huffman_symbol_sequencer: directed self-checking bench for huffman_symbol_sequencer
module tb_huffman_symbol_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    int         vectors = 0;
    int         miscompares = 0;
    logic [639:0] c;
    logic [25:0]  obs_w;

    huffman_symbol_sequencer_if bus ();

`ifdef HUFF_SEQ_STATS_EN
    logic [7:0] stat_sym_cnt;
    logic       stat_zero_blk;
`endif

    huffman_symbol_sequencer dut (
        .clock(clock),
        .reset(reset),
`ifdef HUFF_SEQ_STATS_EN
        .stat_sym_cnt(stat_sym_cnt),
        .stat_zero_blk(stat_zero_blk),
`endif
        .bus(bus)
    );

    always #5 clock = ~clock;

    assign obs_w = {bus.sym_valid, bus.sym_is_dc, bus.sym_ch, bus.sym_run, bus.sym_size,
                    bus.sym_amp, bus.sym_eob, bus.sym_zrl, bus.sym_last};

    // expected symbol word: valid, is_dc, ch, run, size, amp, eob, zrl, last
    function automatic logic [25:0] sw(input logic dc, input int ch, input int run, input int size,
                                       input int amp, input logic eob, input logic zrl, input logic last);
        return {1'b1, dc, 2'(ch), 4'(run), 4'(size), 11'(amp), eob, zrl, last};
    endfunction

    function automatic void put(input int k, input int v);
        c[k*10 +: 10] = 10'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic send(input string tag, input int ch, input logic [639:0] coef, input logic dcr);
        int n = 0;
        bus.sym_ready = 1'b1;
        bus.blk_ch    = 2'(ch);
        bus.blk_coef  = coef;
        bus.dc_reset  = dcr;
        bus.blk_valid = 1'b1;
        while (!bus.blk_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        bus.blk_valid = 1'b0;
        bus.dc_reset  = 1'b0;
        chk({tag, " dc_latency"}, 32'(bus.sym_valid), 32'd1);
    endtask

    task automatic recv(input string tag, input logic [25:0] want);
        int n = 0;
        bus.sym_ready = 1'b1;
        while (!bus.sym_valid && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk(tag, 32'(obs_w), 32'(want));
        @(posedge clock); #1;
    endtask

    task automatic dc_block(input string tag, input int ch, input int coef0, input logic dcr,
                            input int want_ch, input int size, input int amp);
        c = '0;
        put(0, coef0);
        send(tag, ch, c, dcr);
        recv({tag, " dc"}, sw(1'b1, want_ch, 0, size, amp, 1'b0, 1'b0, 1'b0));
        recv({tag, " eob"}, sw(1'b0, want_ch, 0, 0, 0, 1'b1, 1'b0, 1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        bus.blk_valid = 1'b0;
        bus.blk_ch    = '0;
        bus.blk_coef  = '0;
        bus.dc_reset  = 1'b0;
        bus.sym_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset sym", 32'(obs_w), 32'd0);
        chk("reset blk_ready", 32'(bus.blk_ready), 32'd1);
        reset = 1'b0;

        // 1: DC +5 from pred 0, then +2 giving diff -3
        dc_block("t1a", 0, 5, 1'b0, 0, 3, 5);
`ifdef HUFF_SEQ_STATS_EN
        chk("t1a stat_sym_cnt", 32'(stat_sym_cnt), 32'd2);
`endif
        dc_block("t1b", 0, 2, 1'b0, 0, 2, 0);

        // 2: k1=-1, k20=+7 -> (0,1,0), ZRL, (2,3,7), EOB
        c = '0;
        put(0, 2);
        put(1, -1);
        put(20, 7);
        send("t2", 0, c, 1'b0);
        recv("t2 dc", sw(1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0));
        recv("t2 k1", sw(1'b0, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0));
        recv("t2 zrl", sw(1'b0, 0, 15, 0, 0, 1'b0, 1'b1, 1'b0));
        recv("t2 k20", sw(1'b0, 0, 2, 3, 7, 1'b0, 1'b0, 1'b0));
        recv("t2 eob", sw(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1));

        // 3: every AC nonzero, no EOB, last on k=63
        c = '0;
        put(0, -4);
        for (int k = 1; k < 63; k++) put(k, (k % 2 == 1) ? -2 : 3);
        put(63, 1);
        send("t3", 0, c, 1'b0);
        recv("t3 dc", sw(1'b1, 0, 0, 3, 1, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k < 63; k++)
            recv($sformatf("t3 k%0d", k), sw(1'b0, 0, 0, 2, (k % 2 == 1) ? 1 : 3, 1'b0, 1'b0, 1'b0));
        recv("t3 k63", sw(1'b0, 0, 0, 1, 1, 1'b0, 1'b0, 1'b1));

        // 4: backpressure on the second symbol for 5 cycles
        c = '0;
        put(0, 10);
        put(1, 3);
        send("t4", 1, c, 1'b0);
        recv("t4 dc", sw(1'b1, 1, 0, 4, 10, 1'b0, 1'b0, 1'b0));
        bus.sym_ready = 1'b0;
        n = 0;
        while (!bus.sym_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4 hold sym", 32'(obs_w), 32'(sw(1'b0, 1, 0, 2, 3, 1'b0, 1'b0, 1'b0)));
            chk("t4 hold blk_ready", 32'(bus.blk_ready), 32'd0);
            @(posedge clock); #1;
        end
        recv("t4 k1", sw(1'b0, 1, 0, 2, 3, 1'b0, 1'b0, 1'b0));
        chk("t4 busy blk_ready", 32'(bus.blk_ready), 32'd0);
        recv("t4 eob", sw(1'b0, 1, 0, 0, 0, 1'b1, 1'b0, 1'b1));
        chk("t4 idle blk_ready", 32'(bus.blk_ready), 32'd1);

        // 5: per-channel predictors, dc_reset, channel mapping, extreme differences
        dc_block("t5 ch0", 0, 7, 1'b0, 0, 4, 11);
        dc_block("t5 ch1", 1, 4, 1'b0, 1, 3, 1);
        dc_block("t5 ch2", 2, -3, 1'b0, 2, 2, 0);
        dc_block("t5 ch0 same", 0, 7, 1'b0, 0, 0, 0);
        dc_block("t5 dc_reset ch1", 1, 9, 1'b1, 1, 4, 9);
        dc_block("t5 ch2 cleared", 2, -3, 1'b0, 2, 2, 0);
        dc_block("t5 ch3 as ch0", 3, 1, 1'b0, 0, 1, 1);
        dc_block("t5 diff -513", 0, -512, 1'b0, 0, 10, 11'h1FE);
        dc_block("t5 diff 1023", 0, 511, 1'b0, 0, 10, 11'h3FF);

        // 6: reset while a symbol is held
        c = '0;
        put(0, 5);
        put(2, 1);
        put(40, 1);
        send("t6", 2, c, 1'b0);
        recv("t6 dc", sw(1'b1, 2, 0, 4, 8, 1'b0, 1'b0, 1'b0));
        bus.sym_ready = 1'b0;
        n = 0;
        while (!bus.sym_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("t6 held k2", 32'(obs_w), 32'(sw(1'b0, 2, 1, 1, 1, 1'b0, 1'b0, 1'b0)));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t6 reset sym_valid", 32'(bus.sym_valid), 32'd0);
        chk("t6 reset blk_ready", 32'(bus.blk_ready), 32'd1);
        bus.sym_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("t6 no further symbol", 32'(bus.sym_valid), 32'd0);
        dc_block("t6 after reset", 2, 6, 1'b0, 2, 3, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
